// File: rtl/instr_refill_ctrl_pkg.sv
// Shared types and constants for the instruction refill controller.
//   refill_state_t : controller FSM encoding
//   NOP_INSTR      : word returned to fetch when a memory refill times out
package instr_refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    FILL,
    RESP
  } refill_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_refill_ctrl_if.sv
// Bus bundle between the refill controller, the fetch stage, the L2 lookup
// and the memory port. Signal suffixes are from the controller's point of view.
//   master : controller side (accepts fetch requests, drives L2 lookup/fill and memory request)
//   slave  : environment side (fetch stage, L2 array and memory)
//   cpu_*  : fetch request/response handshake
//   l2_*   : L2 lookup address, combinational hit/data, one-cycle fill strobe
//   mem_*  : req/ack memory port, data valid with ack
interface instr_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  cpu_req_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic                  cpu_ready_o;
  logic                  cpu_valid_o;
  logic [DATA_WIDTH-1:0] cpu_data_o;
  logic                  cpu_err_o;

  logic [ADDR_WIDTH-1:0] l2_addr_o;
  logic                  l2_hit_i;
  logic [DATA_WIDTH-1:0] l2_data_i;
  logic                  l2_fill_valid_o;
  logic [DATA_WIDTH-1:0] l2_fill_data_o;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_ack_i;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport master (
    input  cpu_req_i, cpu_addr_i,
    output cpu_ready_o, cpu_valid_o, cpu_data_o, cpu_err_o,
    output l2_addr_o,
    input  l2_hit_i, l2_data_i,
    output l2_fill_valid_o, l2_fill_data_o,
    output mem_req_o, mem_addr_o,
    input  mem_ack_i, mem_data_i
  );

  modport slave (
    output cpu_req_i, cpu_addr_i,
    input  cpu_ready_o, cpu_valid_o, cpu_data_o, cpu_err_o,
    input  l2_addr_o,
    output l2_hit_i, l2_data_i,
    input  l2_fill_valid_o, l2_fill_data_o,
    input  mem_req_o, mem_addr_o,
    output mem_ack_i, mem_data_i
  );

endinterface

// File: rtl/instr_refill_ctrl_sat_counter.sv
// Saturating event counter: counts inc_i pulses, holds at all-ones.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   inc_i : increment request for this cycle
//   cnt_o : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/instr_refill_ctrl.sv
// Instruction refill sequencer between fetch and the L2 instruction cache.
// Holds one fetch address, looks it up in L2, and on a miss fetches the word
// over the memory req/ack port, fills L2 for one cycle and returns the word.
// A memory request that is not acked within TIMEOUT_CYCLES returns NOP with
// an error flag. Hit and miss events feed saturating performance counters.
//   clk, rst    : clock and synchronous active-high reset
//   bus_if      : fetch / L2 / memory bundle (controller-side modport)
//   hit_cnt_o   : L2 hits since reset, saturating
//   miss_cnt_o  : L2 misses since reset, saturating
module instr_refill_ctrl
  import instr_refill_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_refill_ctrl_if.master  bus_if,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  refill_state_t         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  ready_q;
  logic                  valid_q;
  logic                  mem_req_q;
  logic                  fill_q;
  logic [TW-1:0]         timer_q;

  logic hit_inc;
  logic miss_inc;

  // All outputs are registered: each flag is set on the edge that enters the
  // state in which it must be visible, so it is high exactly for that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      mem_req_q <= 1'b0;
      fill_q    <= 1'b0;
      timer_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      fill_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_if.cpu_req_i) begin
            addr_q  <= bus_if.cpu_addr_i;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (bus_if.l2_hit_i) begin
            data_q  <= bus_if.l2_data_i;
            valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            timer_q   <= '0;
            mem_req_q <= 1'b1;
            state_q   <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          // Ack is checked first so it wins over a timeout in the same cycle.
          if (bus_if.mem_ack_i) begin
            data_q    <= bus_if.mem_data_i;
            mem_req_q <= 1'b0;
            fill_q    <= 1'b1;
            state_q   <= FILL;
          end else if (timer_q == TIMER_LAST) begin
            data_q    <= DATA_WIDTH'(NOP_INSTR);
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        FILL: begin
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q   <= 1'b1;
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign hit_inc  = (state_q == LOOKUP) &&  bus_if.l2_hit_i;
  assign miss_inc = (state_q == LOOKUP) && !bus_if.l2_hit_i;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hit_inc),
    .cnt_o (hit_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (miss_inc),
    .cnt_o (miss_cnt_o)
  );

  assign bus_if.cpu_ready_o     = ready_q;
  assign bus_if.cpu_valid_o     = valid_q;
  assign bus_if.cpu_data_o      = data_q;
  assign bus_if.cpu_err_o       = err_q;
  assign bus_if.l2_addr_o       = addr_q;
  assign bus_if.l2_fill_valid_o = fill_q;
  assign bus_if.l2_fill_data_o  = data_q;
  assign bus_if.mem_req_o       = mem_req_q;
  assign bus_if.mem_addr_o      = addr_q;

endmodule

// File: tb/tb_instr_refill_ctrl.sv
// Directed bench for instr_refill_ctrl. Instance A (TIMEOUT_CYCLES=8) runs
// against a small 4-entry L2 model; instance B (CNT_WIDTH=2) sees a permanent
// L2 hit and is used for counter saturation.
module tb_instr_refill_ctrl;

  logic clk;
  logic rst;

  int n_assert = 0;
  int n_fail   = 0;

  instr_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  instr_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  logic [15:0] hit_cnt_a, miss_cnt_a;
  logic [1:0]  hit_cnt_b, miss_cnt_b;

  instr_refill_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus_if     (ifa),
    .hit_cnt_o  (hit_cnt_a),
    .miss_cnt_o (miss_cnt_a)
  );

  instr_refill_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_WIDTH(2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus_if     (ifb),
    .hit_cnt_o  (hit_cnt_b),
    .miss_cnt_o (miss_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // L2 model for instance A: 4 entries, preload port, round-robin fill.
  logic        pre_en;
  logic [31:0] pre_addr, pre_data;
  logic [31:0] l2_tag [4];
  logic [31:0] l2_dat [4];
  logic        l2_v   [4];
  int          l2_ptr;
  logic        m_hit;
  logic [31:0] m_data;

  always @(posedge clk) begin
    if (pre_en) begin
      l2_tag[0] <= pre_addr;
      l2_dat[0] <= pre_data;
      l2_v[0]   <= 1'b1;
    end else if (rst) begin
      for (int i = 0; i < 4; i++) l2_v[i] <= 1'b0;
      l2_ptr <= 1;
    end else if (ifa.l2_fill_valid_o === 1'b1) begin
      l2_tag[l2_ptr] <= ifa.l2_addr_o;
      l2_dat[l2_ptr] <= ifa.l2_fill_data_o;
      l2_v[l2_ptr]   <= 1'b1;
      l2_ptr         <= (l2_ptr + 1) % 4;
    end
  end

  always_comb begin
    m_hit  = 1'b0;
    m_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (l2_v[i] === 1'b1 && l2_tag[i] === ifa.l2_addr_o) begin
        m_hit  = 1'b1;
        m_data = l2_dat[i];
      end
    end
  end

  assign ifa.l2_hit_i  = m_hit;
  assign ifa.l2_data_i = m_data;

  // Output event monitor for instance A, sampled mid-cycle.
  int          cyc_n = 0;
  int          n_memreq = 0, n_fill = 0, n_valid = 0;
  int          fill_cyc = 0, valid_cyc = 0;
  logic [31:0] last_mem_addr = '0, last_fill_data = '0;
  int          n_busy_ready = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (ifa.mem_req_o === 1'b1) begin
      n_memreq      <= n_memreq + 1;
      last_mem_addr <= ifa.mem_addr_o;
    end
    if (ifa.l2_fill_valid_o === 1'b1) begin
      n_fill         <= n_fill + 1;
      fill_cyc       <= cyc_n;
      last_fill_data <= ifa.l2_fill_data_o;
    end
    if (ifa.cpu_valid_o === 1'b1) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc_n;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one fetch on A; ack on the ack_after-th MEM_REQ cycle (0 = never).
  // lat counts edges from the accepting edge to the first cycle with valid.
  task automatic do_req(input logic [31:0] addr, input int ack_after,
                        input logic [31:0] mdata, output int lat);
    int mcnt;
    int guard;
    guard = 0;
    while (ifa.cpu_ready_o !== 1'b1 && guard < 50) begin
      cyc();
      guard++;
    end
    ifa.cpu_req_i  = 1'b1;
    ifa.cpu_addr_i = addr;
    ifa.mem_data_i = mdata;
    mcnt = 0;
    cyc();
    ifa.cpu_req_i = 1'b0;
    lat = 1;
    while (ifa.cpu_valid_o !== 1'b1 && lat < 60) begin
      if (ifa.cpu_ready_o !== 1'b0) n_busy_ready++;
      if (ifa.mem_req_o === 1'b1) begin
        mcnt++;
        ifa.mem_ack_i = (ack_after != 0 && mcnt == ack_after);
      end else begin
        ifa.mem_ack_i = 1'b0;
      end
      cyc();
      lat++;
    end
    ifa.mem_ack_i = 1'b0;
  endtask

  initial begin
    int lat, m0, f0, v0, vb;

    rst = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    ifa.cpu_req_i = 1'b0; ifa.cpu_addr_i = '0;
    ifa.mem_ack_i = 1'b0; ifa.mem_data_i = '0;
    ifb.cpu_req_i = 1'b0; ifb.cpu_addr_i = 32'h40;
    ifb.l2_hit_i = 1'b1;  ifb.l2_data_i = 32'hCAFE_0001;
    ifb.mem_ack_i = 1'b0; ifb.mem_data_i = '0;

    repeat (3) cyc();
    rst = 1'b0;
    pre_en = 1'b1; pre_addr = 32'h100; pre_data = 32'hDEAD_BEEF;
    cyc();
    pre_en = 1'b0;

    // Reset state
    chk("rst_ready",   ifa.cpu_ready_o,     1'b1);
    chk("rst_valid",   ifa.cpu_valid_o,     1'b0);
    chk("rst_err",     ifa.cpu_err_o,       1'b0);
    chk("rst_data",    ifa.cpu_data_o,      32'h0);
    chk("rst_memreq",  ifa.mem_req_o,       1'b0);
    chk("rst_fill",    ifa.l2_fill_valid_o, 1'b0);
    chk("rst_l2addr",  ifa.l2_addr_o,       32'h0);
    chk("rst_hitcnt",  hit_cnt_a,           16'd0);
    chk("rst_misscnt", miss_cnt_a,          16'd0);

    // 1: L2 hit at 0x100
    m0 = n_memreq; f0 = n_fill;
    do_req(32'h100, 0, 32'h0, lat);
    chk("t1_lat",     lat,            2);
    chk("t1_data",    ifa.cpu_data_o, 32'hDEAD_BEEF);
    chk("t1_err",     ifa.cpu_err_o,  1'b0);
    chk("t1_hitcnt",  hit_cnt_a,      16'd1);
    chk("t1_misscnt", miss_cnt_a,     16'd0);
    chk("t1_no_mem",  n_memreq - m0,  0);
    chk("t1_no_fill", n_fill - f0,    0);
    cyc();
    chk("t1_valid_pulse", ifa.cpu_valid_o, 1'b0);
    chk("t1_ready_back",  ifa.cpu_ready_o, 1'b1);

    // 2: miss at 0x200, ack on third MEM_REQ cycle
    m0 = n_memreq; f0 = n_fill;
    do_req(32'h200, 3, 32'h00A0_0093, lat);
    chk("t2_lat",      lat,            6);
    chk("t2_data",     ifa.cpu_data_o, 32'h00A0_0093);
    chk("t2_err",      ifa.cpu_err_o,  1'b0);
    chk("t2_misscnt",  miss_cnt_a,     16'd1);
    chk("t2_hitcnt",   hit_cnt_a,      16'd1);
    cyc();
    chk("t2_memcyc",    n_memreq - m0,  3);
    chk("t2_memaddr",   last_mem_addr,  32'h200);
    chk("t2_fills",     n_fill - f0,    1);
    chk("t2_filldata",  last_fill_data, 32'h00A0_0093);
    chk("t2_fill2resp", valid_cyc - fill_cyc, 1);

    // 2b: back-to-back repeat to 0x200 now hits in L2
    f0 = n_fill;
    do_req(32'h200, 0, 32'h0, lat);
    chk("t2b_lat",    lat,            2);
    chk("t2b_data",   ifa.cpu_data_o, 32'h00A0_0093);
    chk("t2b_hitcnt", hit_cnt_a,      16'd2);
    chk("t2b_fill",   n_fill - f0,    0);

    // 3: miss at 0x300, no ack -> timeout after 8 request cycles
    m0 = n_memreq; f0 = n_fill;
    do_req(32'h300, 0, 32'h5555_5555, lat);
    chk("t3_lat",     lat,            10);
    chk("t3_err",     ifa.cpu_err_o,  1'b1);
    chk("t3_data",    ifa.cpu_data_o, 32'h0000_0013);
    chk("t3_misscnt", miss_cnt_a,     16'd2);
    cyc();
    chk("t3_memcyc",  n_memreq - m0,  8);
    chk("t3_nofill",  n_fill - f0,    0);

    // 4: ack arrives in the last timeout cycle -> fill, no error
    f0 = n_fill;
    do_req(32'h400, 8, 32'h1111_1111, lat);
    chk("t4_lat",     lat,            11);
    chk("t4_err",     ifa.cpu_err_o,  1'b0);
    chk("t4_data",    ifa.cpu_data_o, 32'h1111_1111);
    chk("t4_misscnt", miss_cnt_a,     16'd3);
    cyc();
    chk("t4_fill",     n_fill - f0,    1);
    chk("t4_filldata", last_fill_data, 32'h1111_1111);
    chk("busy_never_ready", n_busy_ready, 0);

    // 5: reset while in MEM_REQ, then a late ack
    ifa.cpu_req_i = 1'b1; ifa.cpu_addr_i = 32'h500;
    cyc();
    ifa.cpu_req_i = 1'b0;
    cyc();
    chk("t5_in_memreq", ifa.mem_req_o, 1'b1);
    cyc(); cyc();
    v0 = n_valid; f0 = n_fill;
    rst = 1'b1;
    cyc();
    chk("t5_rst_memreq", ifa.mem_req_o,   1'b0);
    chk("t5_rst_ready",  ifa.cpu_ready_o, 1'b1);
    rst = 1'b0;
    ifa.mem_ack_i = 1'b1; ifa.mem_data_i = 32'h7777_7777;
    cyc();
    ifa.mem_ack_i = 1'b0;
    repeat (3) cyc();
    chk("t5_novalid",  n_valid - v0,    0);
    chk("t5_nofill",   n_fill - f0,     0);
    chk("t5_hitcnt",   hit_cnt_a,       16'd0);
    chk("t5_misscnt",  miss_cnt_a,      16'd0);
    chk("t5_memreq",   ifa.mem_req_o,   1'b0);
    chk("t5_ready",    ifa.cpu_ready_o, 1'b1);

    // 6: 2-bit counters saturate after five hits
    chk("t6_start", hit_cnt_b, 2'd0);
    ifb.cpu_req_i = 1'b1;
    vb = 0;
    for (int g = 0; g < 60 && vb < 5; g++) begin
      cyc();
      if (ifb.cpu_valid_o === 1'b1) begin
        vb++;
        if (vb == 2) chk("t6_two", hit_cnt_b, 2'd2);
      end
    end
    ifb.cpu_req_i = 1'b0;
    chk("t6_resps",   vb,             5);
    chk("t6_sat",     hit_cnt_b,      2'd3);
    chk("t6_data",    ifb.cpu_data_o, 32'hCAFE_0001);
    chk("t6_nomiss",  miss_cnt_b,     2'd0);
    repeat (3) cyc();
    chk("t6_hold",    hit_cnt_b,      2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
